// File: rtl/serial_transmitter.sv
// Serialises one DATA_W-bit word per frame (start, data LSB first, optional even parity, stop) on a registered line.
// A word is taken in IDLE or STOP when TX_Data_Valid meets TX_Ready; a held Valid chains frames with no idle gap.
module serial_transmitter #(
   parameter int unsigned DATA_W    = 55,
   parameter bit          PARITY_EN = 1'b1
) (
   input  logic              Clk_S,
   input  logic              Rst,
   input  logic [DATA_W-1:0] TX_Data,
   input  logic              TX_Data_Valid,
   output logic              TX_Ready,
   output logic              S_Data
);

   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                parity_q, parity_d;
   logic                s_data_q, s_data_d;
   logic                accept;

   assign TX_Ready = ((state_q == IDLE) || (state_q == STOP)) && !Rst;
   assign accept   = TX_Ready && TX_Data_Valid;
   assign S_Data   = s_data_q;

   // s_data_d carries the bit for the state being entered, so the line is
   // already correct in the first cycle of every state.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      parity_d = parity_q;
      s_data_d = s_data_q;
      case (state_q)
         IDLE, STOP: begin
            s_data_d = 1'b1;
            state_d  = IDLE;
            if (accept) begin
               state_d  = START;
               shift_d  = TX_Data;
               parity_d = ^TX_Data;
               cnt_d    = '0;
               s_data_d = 1'b0;
            end
         end
         START: begin
            state_d  = DATA;
            s_data_d = shift_q[0];
            shift_d  = shift_q >> 1;
            cnt_d    = '0;
         end
         DATA: begin
            if (cnt_q == LAST_BIT) begin
               if (PARITY_EN) begin
                  state_d  = PARITY;
                  s_data_d = parity_q;
               end else begin
                  state_d  = STOP;
                  s_data_d = 1'b1;
               end
            end else begin
               s_data_d = shift_q[0];
               shift_d  = shift_q >> 1;
               cnt_d    = cnt_q + CNT_W'(1);
            end
         end
         PARITY: begin
            state_d  = STOP;
            s_data_d = 1'b1;
         end
         default: begin
            state_d  = IDLE;
            s_data_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge Clk_S) begin
      if (Rst) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         parity_q <= 1'b0;
         s_data_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         parity_q <= parity_d;
         s_data_q <= s_data_d;
      end
   end

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter at default parameters (55 data bits, even parity, 58-cycle frame).
module tb_serial_transmitter;

   localparam int DW    = 55;
   localparam int FLEN  = DW + 3;

   logic          clk;
   logic          rst;
   logic [DW-1:0] tx_data;
   logic          tx_vld;
   logic          tx_rdy;
   logic          s_data;

   int n_chk  = 0;
   int n_fail = 0;

   serial_transmitter dut (
      .Clk_S        (clk),
      .Rst          (rst),
      .TX_Data      (tx_data),
      .TX_Data_Valid(tx_vld),
      .TX_Ready     (tx_rdy),
      .S_Data       (s_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected line value at frame position i for word w.
   function automatic logic frame_bit(input logic [DW-1:0] w, input int i);
      if (i == 0)        return 1'b0;
      else if (i <= DW)  return w[i-1];
      else if (i == DW+1) return ^w;
      else               return 1'b1;
   endfunction

   // Present w and wait (bounded) for the acceptance edge; returns in cycle 0.
   task automatic start_word(input logic [DW-1:0] w);
      int k;
      tx_data = w;
      tx_vld  = 1'b1;
      #1;
      for (k = 0; k < 200 && !tx_rdy; k++) tick();
      chk("accept_wait", {63'd0, tx_rdy}, 64'd1);
      tick();
   endtask

   // Called in cycle 0 of a frame for word w; checks all FLEN cycles.
   task automatic run_frame(input logic [DW-1:0] w, input logic keep_vld,
                            input logic [DW-1:0] nxt, input logic corrupt);
      tx_vld  = keep_vld;
      tx_data = nxt;
      for (int i = 0; i < FLEN; i++) begin
         if (corrupt && i == 10) tx_data = '1;
         #1;
         chk($sformatf("sdata[%0d]", i), {63'd0, s_data}, {63'd0, frame_bit(w, i)});
         chk($sformatf("ready[%0d]", i), {63'd0, tx_rdy}, {63'd0, (i == FLEN-1)});
         tick();
      end
   endtask

   logic [DW-1:0] w_b0, w_ones, w_2a, w_15, w_5;

   initial begin
      w_b0   = 55'h1;
      w_ones = '1;
      w_2a   = 55'h2A;
      w_15   = 55'h15;
      w_5    = 55'h5;

      // Reset with Valid asserted: must not accept
      rst     = 1'b1;
      tx_vld  = 1'b1;
      tx_data = w_ones;
      tick();
      tick();
      chk("rst_sdata", {63'd0, s_data}, 64'd1);
      chk("rst_ready", {63'd0, tx_rdy}, 64'd0);
      rst    = 1'b0;
      tx_vld = 1'b0;
      #1;
      chk("post_rst_ready", {63'd0, tx_rdy}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_sdata", {63'd0, s_data}, 64'd1);
         chk("idle_ready", {63'd0, tx_rdy}, 64'd1);
      end

      // Single word with only bit 0 set: 0,1,54x0,parity 1,stop 1
      start_word(w_b0);
      run_frame(w_b0, 1'b0, '0, 1'b0);
      chk("after_frame_sdata", {63'd0, s_data}, 64'd1);
      chk("after_frame_ready", {63'd0, tx_rdy}, 64'd1);
      chk("parity_b0", {63'd0, frame_bit(w_b0, DW+1)}, 64'd1);

      // All zeros, then all ones (55 ones -> odd count -> parity 1)
      start_word('0);
      run_frame('0, 1'b0, '0, 1'b0);
      start_word(w_ones);
      run_frame(w_ones, 1'b0, '0, 1'b0);

      // Back-to-back: 2A then 15 with Valid held; frame 2 starts right after stop
      tick();
      start_word(w_2a);
      run_frame(w_2a, 1'b1, w_15, 1'b0);
      run_frame(w_15, 1'b0, '0, 1'b0);
      chk("b2b_idle_sdata", {63'd0, s_data}, 64'd1);

      // TX_Data changes mid-frame must not leak in
      start_word('0);
      run_frame('0, 1'b0, '0, 1'b1);

      // Reset at cycle 20 aborts the frame
      tx_data = '0;
      start_word(w_5);
      tx_vld = 1'b0;
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("pre_abort[%0d]", i), {63'd0, s_data}, {63'd0, frame_bit(w_5, i)});
         tick();
      end
      rst = 1'b1;
      #1;
      chk("abort_ready_in_rst", {63'd0, tx_rdy}, 64'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("abort_sdata", {63'd0, s_data}, 64'd1);
      chk("abort_ready", {63'd0, tx_rdy}, 64'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("abort_idle_sdata", {63'd0, s_data}, 64'd1);
      end
      start_word(w_2a);
      run_frame(w_2a, 1'b0, '0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
